load_align_unit: RTL

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit_if.sv | 27 ++
 rtl/load_align_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/load_align_unit_if.sv
// Load-align bundle: request (offset/size), memory beats and the aligned response.
interface load_align_unit_if #(
    parameter int XLEN = 32
) ();
    localparam int OFFW = $clog2(XLEN / 8);

    logic            req_valid;
    logic            req_ready;
    logic [OFFW-1:0] req_off;
    logic [2:0]      req_size;
    logic            mem_valid;
    logic [XLEN-1:0] mem_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_off, req_size, mem_valid, mem_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_off, req_size, mem_valid, mem_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// Aligns and sign/zero-extends loads, splitting word-spanning ones into two beats; result 1 cycle after the last beat.
// Backpressure: one load in flight, the response is held until rsp_ready and only then is a new request taken.
module load_align_unit #(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    load_align_unit_if.slave bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state;
    logic [OFFW-1:0] off_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] part_q;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_err_q;

    function automatic logic [3:0] size_bytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd1: size_bytes = 4'd1;
            3'd2, 3'd3: size_bytes = 4'd2;
            3'd4, 3'd5: size_bytes = 4'd4;
            default:    size_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] sz);
        is_illegal = (XLEN == 32) ? (sz > 3'd4) : (sz == 3'd7);
    endfunction

    function automatic logic spans(input logic [OFFW-1:0] off, input logic [2:0] sz);
        spans = (5'(off) + 5'(size_bytes(sz))) > 5'(NB);
    endfunction

    // Mask keeps the field; its top bit drives sign replication for the signed codes.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] f, input logic [2:0] sz);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] top;
        logic            sgn;
        int              w;
        w    = 8 * int'(size_bytes(sz));
        mask = (w >= XLEN) ? '1 : ((XLEN'(1) << w) - XLEN'(1));
        top  = mask & ~(mask >> 1);
        sgn  = ((sz == 3'd0) || (sz == 3'd2) || (sz == 3'd4)) && (|(f & top));
        extend = sgn ? (f | ~mask) : (f & mask);
    endfunction

    // Beat 0 supplies NB-off low bytes of the field; beat 1 fills in above them.
    logic [OFFW:0]   lo_cnt;
    logic [XLEN-1:0] beat0_field;
    logic [XLEN-1:0] beat1_field;

    assign lo_cnt      = (OFFW+1)'(NB) - {1'b0, off_q};
    assign beat0_field = bus.mem_data >> {off_q, 3'b000};
    assign beat1_field = part_q | (bus.mem_data << {lo_cnt, 3'b000});

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            off_q      <= '0;
            size_q     <= '0;
            part_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q  <= bus.req_off;
                        size_q <= bus.req_size;
                        if (is_illegal(bus.req_size) ||
                            (!MISALIGN_EN && spans(bus.req_off, bus.req_size))) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (bus.mem_valid) begin
                        if (spans(off_q, size_q)) begin
                            part_q <= beat0_field;
                            state  <= BEAT1;
                        end else begin
                            rsp_data_q <= extend(beat0_field, size_q);
                            rsp_err_q  <= 1'b0;
                            state      <= RESP;
                        end
                    end
                end
                BEAT1: begin
                    if (bus.mem_valid) begin
                        rsp_data_q <= extend(beat1_field, size_q);
                        rsp_err_q  <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
